// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock/reset sequencer: FSM encoding,
// divider width and the clock-enable decode patterns.
package clk_rst_pkg;

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_UNUSED = 2'd3
   } seq_state_t;

   localparam int unsigned DIV_W = 4;

   // Each enable fires when the masked divider bits are all ones, which keeps
   // the slower enables nested inside the faster ones.
   localparam logic [DIV_W-1:0] CEN6_MASK    = 4'b0011;
   localparam logic [DIV_W-1:0] CEN6_MATCH   = 4'd3;
   localparam logic [DIV_W-1:0] CEN3_MASK    = 4'b0111;
   localparam logic [DIV_W-1:0] CEN3_MATCH   = 4'd7;
   localparam logic [DIV_W-1:0] CEN1P5_MASK  = 4'b1111;
   localparam logic [DIV_W-1:0] CEN1P5_MATCH = 4'd15;

   function automatic logic cen_hit(input logic [DIV_W-1:0] div,
                                    input logic [DIV_W-1:0] mask,
                                    input logic [DIV_W-1:0] match);
      return (div & mask) == match;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; output
// is the input delayed by STAGES clock edges, all flops clear on reset.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Lock-qualified core reset sequencer with 6/3/1.5 MHz clock-enable
// generation from the 24 MHz PLL clock.
module clk_rst_sequencer #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned SETTLE_CYCLES = 4096
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       soft_rst,
   input  logic       pause,
   output logic       core_rst,
   output logic       cen6,
   output logic       cen3,
   output logic       cen1p5,
   output logic       lock_lost,
   output logic [1:0] state_dbg
);
   import clk_rst_pkg::*;

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] settle_cnt;
   logic [DIV_W-1:0] div;
   logic             locked_s;
   logic             clk_active_c;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk (clk_sys),
      .rst (reset),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Reset sequencing: wait for a clean run of lock before releasing the core.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= ST_HOLD;
         settle_cnt <= '0;
         core_rst   <= 1'b1;
         lock_lost  <= 1'b0;
      end else begin
         case (state)
            ST_HOLD: begin
               core_rst   <= 1'b1;
               settle_cnt <= '0;
               if (locked_s) begin
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!locked_s) begin
                  state    <= ST_HOLD;
                  core_rst <= 1'b1;
               end else if (soft_rst) begin
                  settle_cnt <= '0;
               end else if (settle_cnt == CNT_LAST) begin
                  state    <= ST_RUN;
                  core_rst <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               // Lock loss takes priority over a simultaneous soft reset.
               if (!locked_s) begin
                  state     <= ST_HOLD;
                  core_rst  <= 1'b1;
                  lock_lost <= 1'b1;
               end else if (soft_rst) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
                  core_rst   <= 1'b1;
               end
            end
            default: begin
               state    <= ST_HOLD;
               core_rst <= 1'b1;
            end
         endcase
      end
   end

   assign clk_active_c = (state == ST_SETTLE) || (state == ST_RUN);

   // Divider keeps running through SETTLE so the CPUs are clocked while in reset.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         div    <= '0;
         cen6   <= 1'b0;
         cen3   <= 1'b0;
         cen1p5 <= 1'b0;
      end else begin
         if (!clk_active_c) begin
            div <= '0;
         end else if (!pause) begin
            div <= div + DIV_W'(1);
         end
         cen6   <= clk_active_c && !pause && cen_hit(div, CEN6_MASK, CEN6_MATCH);
         cen3   <= clk_active_c && !pause && cen_hit(div, CEN3_MASK, CEN3_MATCH);
         cen1p5 <= clk_active_c && !pause && cen_hit(div, CEN1P5_MASK, CEN1P5_MATCH);
      end
   end

   assign state_dbg = state;

endmodule
